alu_result_stage: RTL and testbench

//  Registered stage directly downstream of ALU_Integer. Captures saturated result Out and flags N/V/Z

---
 rtl/alu_result_stage.sv | 116 +++++++++++
 tb/tb_alu_result_stage.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_result_stage
// Purpose  : Registered result stage after ALU_Integer: 2-entry skid FIFO to
//            writeback plus NZV status, sticky overflow and overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_out,
    input  logic                  in_n,
    input  logic                  in_v,
    input  logic                  in_z,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_setflags,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [2:0]            flags_nzv,
    output logic                  sticky_v,
    input  logic                  clr_sticky,
    output logic [CNT_WIDTH-1:0]  sat_count
);

    localparam logic [1:0]           c_FULL    = 2'd2;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [DATA_WIDTH-1:0] r_mem_data [2];
    logic [REG_ADDR_W-1:0] r_mem_rd   [2];
    logic                  r_head;
    logic                  r_tail;
    logic [1:0]            r_count;
    logic [DATA_WIDTH-1:0] r_hold_data;
    logic [REG_ADDR_W-1:0] r_hold_rd;
    logic [2:0]            r_flags;
    logic                  r_sticky;
    logic [CNT_WIDTH-1:0]  r_sat;

    logic w_push;
    logic w_pop;

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !rst && (r_count != c_FULL);
    assign out_valid = (r_count != 2'd0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_mem_data[i] <= '0;
                r_mem_rd[i]   <= '0;
            end
            r_head      <= 1'b0;
            r_tail      <= 1'b0;
            r_count     <= 2'd0;
            r_hold_data <= '0;
            r_hold_rd   <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_tail] <= in_out;
                r_mem_rd[r_tail]   <= in_rd;
                r_tail             <= ~r_tail;
            end
            // Remember the departing head so an empty FIFO keeps showing it.
            if (w_pop) begin
                r_head      <= ~r_head;
                r_hold_data <= r_mem_data[r_head];
                r_hold_rd   <= r_mem_rd[r_head];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags  <= 3'b000;
            r_sticky <= 1'b0;
            r_sat    <= '0;
        end else begin
            if (w_push && in_setflags) begin
                r_flags <= {in_n, in_z, in_v};
            end
            // A new overflow on the same edge beats the clear request.
            if (w_push && in_setflags && in_v) begin
                r_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_sticky <= 1'b0;
            end
            if (w_push && in_v && (r_sat != c_CNT_MAX)) begin
                r_sat <= r_sat + c_CNT_ONE;
            end
        end
    end

    assign out_data  = out_valid ? r_mem_data[r_head] : r_hold_data;
    assign out_rd    = out_valid ? r_mem_rd[r_head]   : r_hold_rd;
    assign flags_nzv = r_flags;
    assign sticky_v  = r_sticky;
    assign sat_count = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_result_stage
// Purpose  : Self-checking bench for alu_result_stage against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_out = 8'h00;
    logic       in_n = 1'b0;
    logic       in_v = 1'b0;
    logic       in_z = 1'b0;
    logic [3:0] in_rd = 4'h0;
    logic       in_setflags = 1'b0;
    logic       out_ready = 1'b0;
    logic       clr_sticky = 1'b0;

    wire        in_ready;
    wire        out_valid;
    wire [7:0]  out_data;
    wire [3:0]  out_rd;
    wire [2:0]  flags_nzv;
    wire        sticky_v;
    wire [15:0] sat_count;

    wire        in_ready2;
    wire        out_valid2;
    wire [7:0]  out_data2;
    wire [3:0]  out_rd2;
    wire [2:0]  flags_nzv2;
    wire        sticky_v2;
    wire [1:0]  sat_count2;

    int tests  = 0;
    int failed = 0;

    alu_result_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_out(in_out), .in_n(in_n), .in_v(in_v), .in_z(in_z), .in_rd(in_rd),
        .in_setflags(in_setflags), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .flags_nzv(flags_nzv),
        .sticky_v(sticky_v), .clr_sticky(clr_sticky), .sat_count(sat_count)
    );

    alu_result_stage #(.CNT_WIDTH(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_out(in_out), .in_n(in_n), .in_v(in_v), .in_z(in_z), .in_rd(in_rd),
        .in_setflags(in_setflags), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_rd(out_rd2), .flags_nzv(flags_nzv2),
        .sticky_v(sticky_v2), .clr_sticky(clr_sticky), .sat_count(sat_count2)
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue of {data, rd}.
    logic [11:0] m_q[$];
    logic [11:0] m_last   = 12'h000;
    logic [2:0]  m_flags  = 3'b000;
    logic        m_sticky = 1'b0;
    int          m_sat    = 0;

    task automatic cycle();
        bit push;
        bit pop;
        push = !rst && in_valid && (m_q.size() < 2);
        pop  = !rst && (m_q.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_last = 12'h000; m_flags = 3'b000; m_sticky = 1'b0; m_sat = 0;
        end else begin
            if (pop) m_last = m_q.pop_front();
            if (push) m_q.push_back({in_out, in_rd});
            if (push && in_setflags) m_flags = {in_n, in_z, in_v};
            if (push && in_setflags && in_v) m_sticky = 1'b1;
            else if (clr_sticky) m_sticky = 1'b0;
            if (push && in_v && m_sat < 65535) m_sat++;
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic n, input logic ov,
                         input logic z, input logic [3:0] rd, input logic sf);
        in_valid = v; in_out = d; in_n = n; in_v = ov; in_z = z; in_rd = rd; in_setflags = sf;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        tests++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        cycle();
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count} !== 33'd0) begin
            failed++;
            $display("FAIL reset_outputs got v=%b d=%h rd=%h f=%b s=%b c=%0d exp all 0",
                     out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count);
        end
        tests++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1, 8'h02, 0, 0, 0, 4'd3, 1);
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if ({out_valid, out_data, out_rd, flags_nzv, sat_count} !== {1'b1, 8'h02, 4'd3, 3'b000, 16'd0}) begin
            failed++;
            $display("FAIL basic got v=%b d=%h rd=%0d f=%b c=%0d exp v=1 d=02 rd=3 f=000 c=0",
                     out_valid, out_data, out_rd, flags_nzv, sat_count);
        end
        cycle();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h02) begin
            failed++; $display("FAIL basic_drain got v=%b d=%h exp v=0 d=02", out_valid, out_data);
        end
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        drive(1, 8'h7F, 0, 1, 0, 4'd1, 1);
        cycle();
        drive(1, 8'h80, 1, 1, 0, 4'd2, 1);
        cycle();
        tests++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        drive(1, 8'h55, 0, 0, 0, 4'd9, 1);
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (out_data !== 8'h7F || out_rd !== 4'd1) begin
            failed++; $display("FAIL full_head got d=%h rd=%0d exp d=7f rd=1", out_data, out_rd);
        end
        out_ready = 1'b1;
        cycle();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h80 || out_rd !== 4'd2 || in_ready !== 1'b1) begin
            failed++; $display("FAIL full_second got v=%b d=%h rd=%0d rdy=%b exp v=1 d=80 rd=2 rdy=1",
                               out_valid, out_data, out_rd, in_ready);
        end
        cycle();
        tests++;
        if (out_valid !== 1'b0 || sat_count !== 16'd2 || flags_nzv !== 3'b101) begin
            failed++; $display("FAIL full_end got v=%b c=%0d f=%b exp v=0 c=2 f=101",
                               out_valid, sat_count, flags_nzv);
        end
    endtask

    task automatic test_push_pop();
        out_ready = 1'b0;
        drive(1, 8'h11, 0, 0, 0, 4'd4, 0);
        cycle();
        out_ready = 1'b1;
        drive(1, 8'h0A, 0, 0, 0, 4'd5, 0);
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 8'h0A || out_rd !== 4'd5) begin
            failed++; $display("FAIL pushpop_head got v=%b d=%h rd=%0d exp v=1 d=0a rd=5",
                               out_valid, out_data, out_rd);
        end
        cycle();
        tests++;
        if (out_valid !== 1'b0 || out_data !== 8'h0A) begin
            failed++; $display("FAIL pushpop_drain got v=%b d=%h exp v=0 d=0a", out_valid, out_data);
        end
    endtask

    task automatic test_sticky();
        out_ready = 1'b1;
        clr_sticky = 1'b1;
        cycle();
        clr_sticky = 1'b0;
        tests++;
        if (sticky_v !== 1'b0) begin failed++; $display("FAIL sticky_clear0 got=%b exp=0", sticky_v); end
        drive(1, 8'h7F, 0, 1, 0, 4'd1, 1);
        cycle();
        tests++;
        if (sticky_v !== 1'b1) begin failed++; $display("FAIL sticky_set got=%b exp=1", sticky_v); end
        drive(1, 8'h00, 0, 0, 1, 4'd2, 1);
        cycle();
        tests++;
        if (flags_nzv !== 3'b010 || sticky_v !== 1'b1) begin
            failed++; $display("FAIL sticky_hold got f=%b s=%b exp f=010 s=1", flags_nzv, sticky_v);
        end
        clr_sticky = 1'b1;
        drive(1, 8'h80, 1, 1, 0, 4'd3, 1);
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (sticky_v !== 1'b1) begin failed++; $display("FAIL sticky_set_wins got=%b exp=1", sticky_v); end
        cycle();
        clr_sticky = 1'b0;
        tests++;
        if (sticky_v !== 1'b0) begin failed++; $display("FAIL sticky_clear got=%b exp=0", sticky_v); end
    endtask

    task automatic test_noflags();
        logic [2:0] f0;
        logic       s0;
        int         c0;
        f0 = m_flags; s0 = m_sticky; c0 = m_sat;
        drive(1, 8'h80, 1, 1, 0, 4'd6, 0);
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (flags_nzv !== f0 || sticky_v !== s0 || sat_count !== 16'(c0 + 1)) begin
            failed++; $display("FAIL noflags got f=%b s=%b c=%0d exp f=%b s=%b c=%0d",
                               flags_nzv, sticky_v, sat_count, f0, s0, c0 + 1);
        end
        cycle();
    endtask

    task automatic test_random();
        logic [11:0] e_head;
        int          e_small;
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            clr_sticky = ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom));
            cycle();
            e_head  = (m_q.size() > 0) ? m_q[0] : m_last;
            e_small = (m_sat > 3) ? 3 : m_sat;
            tests++;
            if ({out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count, in_ready, sat_count2} !==
                {m_q.size() > 0, e_head, m_flags, m_sticky, 16'(m_sat), !rst && m_q.size() < 2, 2'(e_small)}) begin
                failed++;
                $display("FAIL random[%0d] got v=%b d=%h rd=%h f=%b s=%b c=%0d rdy=%b c2=%0d exp v=%b d=%h rd=%h f=%b s=%b c=%0d rdy=%b c2=%0d",
                         i, out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count, in_ready, sat_count2,
                         m_q.size() > 0, e_head[11:4], e_head[3:0], m_flags, m_sticky, m_sat,
                         !rst && m_q.size() < 2, e_small);
            end
        end
        rst = 1'b0; clr_sticky = 1'b0;
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1, 8'h33, 0, 1, 0, 4'd7, 1);
        cycle();
        cycle();
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failed++; $display("FAIL rstfull_prefill got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count, sat_count2} !== 35'd0) begin
            failed++; $display("FAIL rstfull_outputs got v=%b d=%h rd=%h f=%b s=%b c=%0d c2=%0d exp all 0",
                               out_valid, out_data, out_rd, flags_nzv, sticky_v, sat_count, sat_count2);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'(i), 0, 1, 0, 4'(i), 0);
            cycle();
        end
        drive(0, 8'h00, 0, 0, 0, 4'd0, 0);
        tests++;
        if (sat_count2 !== 2'd3 || sat_count !== 16'd5) begin
            failed++; $display("FAIL sat_saturate got c2=%0d c=%0d exp c2=3 c=5", sat_count2, sat_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_push_pop();
        test_sticky();
        test_noflags();
        test_random();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
